// File: rtl/multi_nbit_serial.sv
// Bit-serial shift-and-add multiplier.
// Operands arrive LSB first over WIDTH cycles and are multiplied in WIDTH
// shift-and-add steps. The 2*WIDTH-bit product then leaves LSB first, with
// O_VALID marking each product bit.
// Optional build macro: MULTI_SIGNED_EN selects two's-complement operands.
// When it is undefined, the operands are unsigned. Timing is identical in
// both builds.
module multi_nbit_serial #(
   parameter int WIDTH = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic START,
   input  logic A,
   input  logic B,
   output logic O,
   output logic O_VALID,
   output logic BUSY
);

   localparam int PW    = 2 * WIDTH;
   localparam int CNT_W = $clog2(PW + 1);
   localparam logic [CNT_W-1:0] LD_LAST  = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(PW);

   typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]        a_q, a_d;
   logic [WIDTH-1:0]        b_q, b_d;
   logic signed [PW-1:0]    prod_q, prod_d;
   logic                    o_q, o_d;
   logic                    vld_q, vld_d;
   logic                    busy_q, busy_d;
   logic                    neg;
   logic signed [PW-1:0]    pp;

   // Multiplicand widened to the product width (sign- or zero-extended).
   function automatic logic signed [PW-1:0] ext_mcand(input logic [WIDTH-1:0] a);
`ifdef MULTI_SIGNED_EN
      return {{WIDTH{a[WIDTH-1]}}, a};
`else
      return {{WIDTH{1'b0}}, a};
`endif
   endfunction

   // Partial product for one multiplier bit.
   // In signed mode the multiplier MSB carries weight -2^(WIDTH-1), so that
   // term is subtracted rather than added.
   function automatic logic signed [PW-1:0] partial(input logic [WIDTH-1:0] a,
                                                   input logic bit_i,
                                                   input logic [CNT_W-1:0] idx,
                                                   input logic negate);
      logic signed [PW-1:0] p;
      p = bit_i ? (ext_mcand(a) <<< idx) : '0;
      if (negate) p = -p;
      return p;
   endfunction

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      prod_d  = prod_q;
      o_d     = 1'b0;
      vld_d   = 1'b0;
`ifdef MULTI_SIGNED_EN
      neg     = (cnt_q == LD_LAST);
`else
      neg     = 1'b0;
`endif
      pp      = partial(a_q, b_q[0], cnt_q, neg);

      case (state_q)
         IDLE: begin
            if (START) begin
               a_d     = {A, a_q[WIDTH-1:1]};
               b_d     = {B, b_q[WIDTH-1:1]};
               cnt_d   = CNT_W'(1);
               state_d = LOAD;
            end
         end
         LOAD: begin
            a_d = {A, a_q[WIDTH-1:1]};
            b_d = {B, b_q[WIDTH-1:1]};
            if (cnt_q == LD_LAST) begin
               cnt_d   = '0;
               prod_d  = '0;
               state_d = CALC;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CALC: begin
            prod_d = prod_q + pp;
            b_d    = {1'b0, b_q[WIDTH-1:1]};
            if (cnt_q == LD_LAST) begin
               cnt_d   = '0;
               state_d = OUT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         OUT: begin
            if (cnt_q == OUT_LAST) begin
               cnt_d   = '0;
               a_d     = '0;
               b_d     = '0;
               prod_d  = '0;
               state_d = IDLE;
            end else begin
               o_d    = prod_q[0];
               vld_d  = 1'b1;
               prod_d = {1'b0, prod_q[PW-1:1]};
               cnt_d  = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State, datapath and output registers; reset aborts any job in flight
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         prod_q  <= '0;
         o_q     <= 1'b0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         prod_q  <= prod_d;
         o_q     <= o_d;
         vld_q   <= vld_d;
         busy_q  <= busy_d;
      end
   end

   assign O       = o_q;
   assign O_VALID = vld_q;
   assign BUSY    = busy_q;

endmodule

// File: tb/tb_multi_nbit_serial.sv
// Bench for multi_nbit_serial.
// A job-level reference model predicts BUSY, O_VALID and O on every cycle.
// Directed jobs pin known products, and randomized jobs with stray START
// pulses exercise the rest. The bench also covers a mid-job reset and a
// WIDTH=8 instance.
module tb_multi_nbit_serial;

   localparam int W  = 4;
   localparam int PW = 2 * W;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   logic START = 1'b0, A = 1'b0, B = 1'b0;
   logic O, O_VALID, BUSY;
   logic START8 = 1'b0, A8 = 1'b0, B8 = 1'b0;
   logic O8, OV8, BUSY8;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   multi_nbit_serial #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
      .O(O), .O_VALID(O_VALID), .BUSY(BUSY)
   );

   multi_nbit_serial #(.WIDTH(8)) dut8 (
      .CLK(CLK), .RST(RST), .START(START8), .A(A8), .B(B8),
      .O(O8), .O_VALID(OV8), .BUSY(BUSY8)
   );

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference product over 2*W bits from plain integer arithmetic
   function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb;
`ifdef MULTI_SIGNED_EN
      sa = longint'($signed(a));
      sb = longint'($signed(b));
`else
      sa = longint'(a);
      sb = longint'(b);
`endif
      return PW'(sa * sb);
   endfunction

   // Job-level model: which edge accepted the job, and what the operands were
   bit             m_active = 1'b0;
   int             cyc = 0;
   int             t0 = 0;
   logic [W-1:0]   ma = '0, mb = '0;
   logic [PW-1:0]  mprod = '0;

   initial forever begin
      int k;
      @(posedge CLK or negedge RST);
      if (!RST) begin
         m_active = 1'b0;
      end else begin
         cyc++;
         if (m_active) begin
            k = cyc - t0;
            if (k < W) begin
               ma[k] = A;
               mb[k] = B;
            end
            if (k == W - 1) mprod = ref_mul(ma, mb);
            if (k == 4 * W) m_active = 1'b0;
         end else if (START) begin
            m_active = 1'b1;
            t0       = cyc;
            ma[0]    = A;
            mb[0]    = B;
         end
      end
   end

   // Per-cycle compare against the model; also collect the emitted product
   logic [PW-1:0] obs = '0;
   initial forever begin
      int  k;
      logic exp_v, exp_o;
      @(negedge CLK);
      k     = cyc - t0;
      exp_v = m_active && (k >= PW);
      exp_o = 1'b0;
      if (exp_v) exp_o = mprod[k-PW];
      check("BUSY", BUSY, m_active);
      check("O_VALID", O_VALID, exp_v);
      check("O", O, exp_o);
      if (O_VALID) obs = {O, obs[PW-1:1]};
   end

   // Monitor for the WIDTH=8 instance
   int          busy8_cnt = 0;
   int          ov8_cnt = 0;
   logic [15:0] obs8 = '0;
   initial forever begin
      @(negedge CLK);
      if (BUSY8) busy8_cnt++;
      if (OV8) begin
         ov8_cnt++;
         obs8 = {O8, obs8[15:1]};
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_job(input logic [W-1:0] a, input logic [W-1:0] b, input bit noisy);
      for (int k = 0; k < W; k++) begin
         START = (k == 0) ? 1'b1 : (noisy & 1'($urandom));
         A = a[k];
         B = b[k];
         tick();
      end
      for (int n = 0; n <= 4 * W + 2; n++) begin
         if (!BUSY) break;
         START = noisy ? 1'($urandom) : 1'b0;
         A = 1'($urandom);
         B = 1'($urandom);
         tick();
      end
      START = 1'b0;
      check("job_end_busy", BUSY, 0);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      #3;
      check("rst_O", O, 0);
      check("rst_O_VALID", O_VALID, 0);
      check("rst_BUSY", BUSY, 0);
      check("rst_O8", O8, 0);
      check("rst_OV8", OV8, 0);
      check("rst_BUSY8", BUSY8, 0);
      tick();
      tick();
      RST = 1'b1;
      tick();

      // Directed products with literal expectations
      do_job(4'hF, 4'hF, 1'b0);
`ifdef MULTI_SIGNED_EN
      check("prod_FxF", obs, 8'h01);
`else
      check("prod_FxF", obs, 8'hE1);
`endif
      do_job(4'h8, 4'h7, 1'b1);
`ifdef MULTI_SIGNED_EN
      check("prod_8x7", obs, 8'hC8);
`else
      check("prod_8x7", obs, 8'h38);
`endif
      do_job(4'h0, 4'hB, 1'b0);
      check("prod_0xB", obs, 0);
      do_job(4'hD, 4'h0, 1'b1);
      check("prod_Dx0", obs, 0);

      // Randomized jobs, mostly back-to-back, with stray START pulses
      for (int j = 0; j < 40; j++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         do_job(ra, rb, 1'($urandom));
         check("prod_rand", obs, ref_mul(ra, rb));
         if ($urandom_range(0, 3) == 0) begin
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) tick();
         end
      end

      // Reset asserted mid-multiply, between clock edges
      for (int k = 0; k < W; k++) begin
         START = (k == 0);
         A = 1'($urandom);
         B = 1'($urandom);
         tick();
      end
      START = 1'b0;
      tick();
      #2;
      RST = 1'b0;
      #1;
      check("abort_O", O, 0);
      check("abort_O_VALID", O_VALID, 0);
      check("abort_BUSY", BUSY, 0);
      tick();
      tick();
      RST = 1'b1;
      for (int g = 0; g < 6; g++) tick();
      do_job(4'h3, 4'h5, 1'b0);
      check("prod_3x5", obs, 15);

      // WIDTH=8 instance: 0xFF x 0xFF
      busy8_cnt = 0;
      ov8_cnt   = 0;
      for (int k = 0; k < 8; k++) begin
         START8 = (k == 0);
         A8 = 1'b1;
         B8 = 1'b1;
         tick();
      end
      START8 = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (!BUSY8) break;
         tick();
      end
      tick();
      check("w8_busy_end", BUSY8, 0);
      check("w8_busy_cycles", busy8_cnt, 32);
      check("w8_valid_cycles", ov8_cnt, 16);
`ifdef MULTI_SIGNED_EN
      check("w8_prod", obs8, 16'h0001);
`else
      check("w8_prod", obs8, 16'hFE01);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
